edge_relax: RTL and testbench

Edge-relaxation stage of the Dijkstra sample, directly upstream of write_node_update. For the node currently being expanded, it consumes that node's edge records and computes candidate cost = node cost + edge weight. Whenever the candidate is strictly below the neighbour's stored cost, it issues a {write_addr, next_cost, parent_addr} update on the write_valid/write_ready handshake that write_node_update accepts. After the last edge it waits for the write path to drain, then reports done.

---
 rtl/edge_relax_pkg.sv | 42 ++++
 rtl/edge_relax_slice.sv | 43 ++++
 rtl/edge_relax.sv | 163 ++++++++++++++++
 tb/tb_edge_relax.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_relax_pkg.sv
// -----------------------------------------------------------------------------
// edge_relax_pkg
//   Shared definitions for the edge-relaxation stage of the Dijkstra sample.
//   - state_t   : controller states (IDLE, RUN, FLUSH, DRAIN)
//   - W_D_DEF   : default data/address/cost width
//   - W_CNT_DEF : default edge counter width
//   - COST_INF  : "unreached" cost, all-ones of the default width
//   - relax_sum : candidate-cost adder. It wraps by default and saturates when
//                 EDGE_RELAX_SATURATE_EN is defined. This is the only place
//                 that macro is consulted.
// -----------------------------------------------------------------------------
package edge_relax_pkg;

    localparam int W_D_DEF   = 32;
    localparam int W_CNT_DEF = 16;

    localparam logic [W_D_DEF-1:0] COST_INF = {W_D_DEF{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Operands are zero-extended into 64 bits and are at most w bits wide,
    // with w <= 63. The raw sum therefore never loses its carry, and the carry
    // can be tested against the w-bit mask.
    function automatic logic [63:0] relax_sum(input logic [63:0] a,
                                              input logic [63:0] b,
                                              input int unsigned w);
        logic [63:0] mask;
        logic [63:0] s;
        mask = (64'd1 << w) - 64'd1;
        s    = a + b;
`ifdef EDGE_RELAX_SATURATE_EN
        if (s > mask) s = mask;
`endif
        return s & mask;
    endfunction

endpackage

// File: rtl/edge_relax_slice.sv
// -----------------------------------------------------------------------------
// edge_relax_slice
//   A single-entry valid/ready pipeline register with a configurable width.
//   It accepts a new word whenever it is empty or its current word leaves in
//   the same cycle, so it sustains full throughput.
//   Ports:
//     clk, rst           clock, synchronous active-high reset
//     up_valid/up_ready  upstream handshake
//     up_data   [W]      upstream payload
//     dn_valid/dn_ready  downstream handshake
//     dn_data   [W]      registered payload; it is held while dn_valid && !dn_ready
// -----------------------------------------------------------------------------
module edge_relax_slice #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [W-1:0] up_data,
    output logic         dn_valid,
    input  logic         dn_ready,
    output logic [W-1:0] dn_data
);

    assign up_ready = !dn_valid || dn_ready;

    // NOTE: state registers use non-blocking assignments. All flops then
    // update together at the edge, whatever order the blocks are evaluated in.
    always_ff @(posedge clk) begin
        if (rst) begin
            dn_valid <= 1'b0;
            // NOTE: the payload is reset as well as the valid bit. This slice
            // also drives the block's output ports, and those must read 0
            // after reset.
            dn_data  <= '0;
        end else if (up_ready) begin
            dn_valid <= up_valid;
            if (up_valid) dn_data <= up_data;
        end
    end

endmodule

// File: rtl/edge_relax.sv
// -----------------------------------------------------------------------------
// edge_relax
//   Edge-relaxation stage. For the node being expanded, it consumes that
//   node's edge records and computes candidate = node_cost + edge_weight.
//   When the candidate is strictly below the neighbour's stored cost, it
//   emits {write_addr, next_cost, parent_addr} on write_valid/write_ready.
//   After the last edge it waits for the pipeline and the downstream write
//   channel to empty, then pulses done.
//
//   Pipeline: stage 1 (add) -> compare filter -> output register.
//   A record accepted at cycle t appears on write_valid at t+2 when nothing
//   stalls.
//
//   Ports:
//     clk, rst                         clock, synchronous active-high reset
//     start, node_addr, node_cost,
//     edge_count                       expansion request, sampled in IDLE only
//     busy, done, update_count         status
//     edge_valid/edge_ready, edge_dst,
//     edge_weight, edge_dst_cost       edge record stream
//     write_valid/write_ready,
//     write_addr, next_cost,
//     parent_addr                      update stream toward write_node_update
//     write_empty                      downstream write channel is empty
//
//   Build option: EDGE_RELAX_SATURATE_EN makes the candidate adder saturate
//   at all-ones. Without it the adder wraps.
// -----------------------------------------------------------------------------
module edge_relax
    import edge_relax_pkg::*;
#(
    parameter int W_D   = W_D_DEF,
    parameter int W_CNT = W_CNT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W_D-1:0]   node_addr,
    input  logic [W_D-1:0]   node_cost,
    input  logic [W_CNT-1:0] edge_count,
    output logic             busy,
    output logic             done,
    output logic [W_CNT-1:0] update_count,
    input  logic             edge_valid,
    output logic             edge_ready,
    input  logic [W_D-1:0]   edge_dst,
    input  logic [W_D-1:0]   edge_weight,
    input  logic [W_D-1:0]   edge_dst_cost,
    output logic [W_D-1:0]   write_addr,
    output logic [W_D-1:0]   next_cost,
    output logic [W_D-1:0]   parent_addr,
    output logic             write_valid,
    input  logic             write_ready,
    input  logic             write_empty
);

    state_t           state, state_nxt;
    logic [W_CNT-1:0] remaining;
    logic [W_D-1:0]   cost_q;
    logic [W_D-1:0]   parent_q;

    logic             edge_take;
    logic [W_D-1:0]   sum;

    // Stage 1 carries {dst, candidate sum, neighbour's stored cost}
    logic             s1_up_ready;
    logic             s1_valid;
    logic             s1_ready;
    logic [3*W_D-1:0] s1_data;
    logic [W_D-1:0]   s1_dst, s1_sum, s1_dcost;
    logic             relax;

    // Output register carries {write_addr, next_cost, parent_addr}
    logic             out_up_ready;
    logic [3*W_D-1:0] out_data;

    assign edge_take = edge_valid && edge_ready;
    assign sum       = W_D'(relax_sum(64'(cost_q), 64'(edge_weight), W_D));

    edge_relax_slice #(.W(3*W_D)) u_stage1 (
        .clk      (clk),
        .rst      (rst),
        .up_valid (edge_take),
        .up_ready (s1_up_ready),
        .up_data  ({edge_dst, sum, edge_dst_cost}),
        .dn_valid (s1_valid),
        .dn_ready (s1_ready),
        .dn_data  (s1_data)
    );

    assign {s1_dst, s1_sum, s1_dcost} = s1_data;

    // A non-relaxing record is dropped right here and never waits on the
    // output register. Only a relaxing record needs the output slot.
    assign relax    = s1_sum < s1_dcost;
    assign s1_ready = !relax || out_up_ready;

    edge_relax_slice #(.W(3*W_D)) u_out (
        .clk      (clk),
        .rst      (rst),
        .up_valid (s1_valid && relax),
        .up_ready (out_up_ready),
        .up_data  ({s1_dst, s1_sum, parent_q}),
        .dn_valid (write_valid),
        .dn_ready (write_ready),
        .dn_data  (out_data)
    );

    assign {write_addr, next_cost, parent_addr} = out_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            remaining    <= '0;
            cost_q       <= '0;
            parent_q     <= '0;
            update_count <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                cost_q       <= node_cost;
                parent_q     <= node_addr;
                remaining    <= edge_count;
                update_count <= '0;
            end else begin
                if (edge_take)                  remaining    <= remaining - W_CNT'(1);
                if (write_valid && write_ready) update_count <= update_count + W_CNT'(1);
            end
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first. Then no path
        // through the case statement leaves a signal unassigned, and no latch
        // is inferred.
        state_nxt  = state;
        busy       = (state != IDLE);
        done       = 1'b0;
        edge_ready = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = (edge_count == '0) ? FLUSH : RUN;
            end
            RUN: begin
                // Never looks at edge_valid, so there is no combinational
                // loop through the upstream source.
                edge_ready = (remaining != '0) && s1_up_ready;
                if (edge_take && remaining == W_CNT'(1)) state_nxt = FLUSH;
            end
            FLUSH: begin
                if (!s1_valid && !write_valid) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (write_empty) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_edge_relax.sv
// -----------------------------------------------------------------------------
// tb_edge_relax
//   Self-checking bench for edge_relax. A reference model predicts, for every
//   accepted edge, whether it relaxes and what update it produces. The model
//   computes this from the cost arithmetic directly. The predicted updates go
//   into a queue, and a monitor compares each write handshake against the
//   head of that queue.
//   Build option: EDGE_RELAX_SATURATE_EN switches the model's adder as well.
// -----------------------------------------------------------------------------
module tb_edge_relax;
    import edge_relax_pkg::*;

    localparam int W_D   = 32;
    localparam int W_CNT = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [W_D-1:0]   node_addr = '0;
    logic [W_D-1:0]   node_cost = '0;
    logic [W_CNT-1:0] edge_count = '0;
    logic             busy, done;
    logic [W_CNT-1:0] update_count;
    logic             edge_valid = 1'b0;
    logic             edge_ready;
    logic [W_D-1:0]   edge_dst = '0, edge_weight = '0, edge_dst_cost = '0;
    logic [W_D-1:0]   write_addr, next_cost, parent_addr;
    logic             write_valid;
    logic             write_ready = 1'b0;
    logic             write_empty = 1'b1;

    edge_relax #(.W_D(W_D), .W_CNT(W_CNT)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .node_addr     (node_addr),
        .node_cost     (node_cost),
        .edge_count    (edge_count),
        .busy          (busy),
        .done          (done),
        .update_count  (update_count),
        .edge_valid    (edge_valid),
        .edge_ready    (edge_ready),
        .edge_dst      (edge_dst),
        .edge_weight   (edge_weight),
        .edge_dst_cost (edge_dst_cost),
        .write_addr    (write_addr),
        .next_cost     (next_cost),
        .parent_addr   (parent_addr),
        .write_valid   (write_valid),
        .write_ready   (write_ready),
        .write_empty   (write_empty)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int ready_mode = 0;   // 0: always ready, 1: random, 2: held low
    bit lat_mode   = 1'b0;

    typedef struct {
        logic [W_D-1:0] dst;
        logic [W_D-1:0] cost;
        logic [W_D-1:0] parent;
        int             acc;
    } upd_t;

    upd_t           exp_q[$];
    logic [W_D-1:0] e_dst[$], e_w[$], e_dc[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Candidate cost, computed with plain wide arithmetic
    function automatic logic [W_D-1:0] model_sum(input logic [W_D-1:0] a, input logic [W_D-1:0] b);
        longint unsigned s;
        s = longint'(a) + longint'(b);
`ifdef EDGE_RELAX_SATURATE_EN
        if (s > 64'hFFFF_FFFF) s = 64'hFFFF_FFFF;
`endif
        return s[W_D-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_edge(input logic [W_D-1:0] d, input logic [W_D-1:0] w, input logic [W_D-1:0] dc);
        e_dst.push_back(d);
        e_w.push_back(w);
        e_dc.push_back(dc);
    endtask

    task automatic clear_edges();
        e_dst.delete();
        e_w.delete();
        e_dc.delete();
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       write_ready = 1'b1;
            1:       write_ready = ($urandom_range(0, 2) != 0);
            default: write_ready = 1'b0;
        endcase
    end

    // Monitor: hold stability, latency, and in-order update contents
    initial begin
        logic            prev_wv;
        logic            prev_wr;
        logic [3*W_D-1:0] prev_d;
        prev_wv = 1'b0;
        prev_wr = 1'b0;
        prev_d  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_wv = 1'b0;
            end else begin
                check("edge_ready_only_when_busy", edge_ready & ~busy, 1'b0);
                if (prev_wv && !prev_wr) begin
                    check("hold_valid", write_valid, 1'b1);
                    check("hold_data", {write_addr, next_cost, parent_addr}, prev_d);
                end
                if (write_valid && lat_mode && exp_q.size() > 0)
                    check("latency", cyc - exp_q[0].acc, 2);
                if (write_valid && write_ready) begin
                    check("update_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) begin
                        upd_t u;
                        u = exp_q.pop_front();
                        check("upd_addr",   write_addr,  u.dst);
                        check("upd_cost",   next_cost,   u.cost);
                        check("upd_parent", parent_addr, u.parent);
                    end
                end
                prev_wv = write_valid;
                prev_wr = write_ready;
                prev_d  = {write_addr, next_cost, parent_addr};
            end
        end
    end

    // Expands one node over the edges in e_*. The caller is at posedge+1 on
    // entry and is back at posedge+1 on return.
    task automatic run_node(input logic [W_D-1:0] cost, input logic [W_D-1:0] addr,
                            input bit vrand, input int empty_delay);
        int n;
        int idx;
        int budget;
        int exp_upd;
        bit got_done;
        n        = e_dst.size();
        idx      = 0;
        exp_upd  = 0;
        got_done = 1'b0;
        node_cost  = cost;
        node_addr  = addr;
        edge_count = W_CNT'(n);
        write_empty = (empty_delay == 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        budget = 2000;
        while (idx < n && budget > 0) begin
            edge_valid    = vrand ? ($urandom_range(0, 3) != 0) : 1'b1;
            edge_dst      = e_dst[idx];
            edge_weight   = e_w[idx];
            edge_dst_cost = e_dc[idx];
            if (vrand && $urandom_range(0, 7) == 0) begin
                // A start while busy must be ignored
                start      = 1'b1;
                node_cost  = $urandom;
                node_addr  = $urandom;
                edge_count = W_CNT'($urandom_range(0, 5));
            end
            @(negedge clk);
            if (edge_valid && edge_ready) begin
                if (model_sum(cost, e_w[idx]) < e_dc[idx]) begin
                    exp_q.push_back('{dst: e_dst[idx], cost: model_sum(cost, e_w[idx]),
                                      parent: addr, acc: cyc});
                    exp_upd++;
                end
                idx++;
            end
            tick();
            start = 1'b0;
            budget--;
        end
        check("edges_consumed", idx, n);
        edge_valid = 1'b0;
        for (int k = 0; k < empty_delay; k++) begin
            @(negedge clk);
            check("done_waits_for_empty", done, 1'b0);
            tick();
        end
        write_empty = 1'b1;
        budget = 2000;
        while (!got_done && budget > 0) begin
            @(negedge clk);
            if (done) got_done = 1'b1;
            else begin
                tick();
                budget--;
            end
        end
        check("done_seen", got_done, 1'b1);
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
        if (got_done) begin
            tick();
            @(negedge clk);
            check("idle_after_done_busy", busy, 1'b0);
            check("done_single_pulse", done, 1'b0);
            check("update_count", update_count, exp_upd);
            tick();
        end
    endtask

    initial begin
        int sat_exp;
        // ---------------- reset state ----------------
        rst = 1'b1;
        ready_mode = 0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_edge_ready", edge_ready, 1'b0);
        check("rst_write_valid", write_valid, 1'b0);
        check("rst_write_addr", write_addr, 0);
        check("rst_next_cost", next_cost, 0);
        check("rst_parent_addr", parent_addr, 0);
        check("rst_update_count", update_count, 0);
        tick();
        rst = 1'b0;
        tick();

        // ---------------- basic relax/reject, latency ----------------
        clear_edges();
        add_edge(32'd3, 32'd5, 32'd20);
        add_edge(32'd4, 32'd7, 32'd15);
        lat_mode = 1'b1;
        run_node(32'd10, 32'h77, 1'b0, 2);
        lat_mode = 1'b0;
        check("basic_update_count", update_count, 1);

        // ---------------- equal cost is not a relaxation ----------------
        clear_edges();
        add_edge(32'd8, 32'd5, 32'd10);
        run_node(32'd5, 32'h40, 1'b0, 0);
        check("equal_update_count", update_count, 0);

        // ---------------- backpressure ----------------
        clear_edges();
        for (int i = 0; i < 4; i++) add_edge(32'(10 + i), 32'(1 + i), 32'd1000);
        ready_mode = 2;
        fork
            run_node(32'd100, 32'h55, 1'b0, 0);
            begin
                repeat (4) @(negedge clk);
                check("bp_edge_ready_low", edge_ready, 1'b0);
                check("bp_write_valid", write_valid, 1'b1);
                repeat (4) @(negedge clk);
                check("bp_edge_ready_still_low", edge_ready, 1'b0);
                ready_mode = 0;
            end
        join
        check("bp_update_count", update_count, 4);

        // ---------------- saturation / wrap ----------------
        clear_edges();
        add_edge(32'd9, 32'h20, 32'hFFFF_FFFF);
`ifdef EDGE_RELAX_SATURATE_EN
        sat_exp = 0;
`else
        sat_exp = 1;
`endif
        run_node(32'hFFFF_FFF0, 32'h21, 1'b0, 0);
        check("sat_update_count", update_count, sat_exp);

        // ---------------- zero edges ----------------
        write_empty = 1'b1;
        edge_count  = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("zero_busy_c1", busy, 1'b1);
        check("zero_done_c1", done, 1'b0);
        check("zero_edge_ready_c1", edge_ready, 1'b0);
        tick();
        @(negedge clk);
        check("zero_done_c2", done, 1'b1);
        check("zero_edge_ready_c2", edge_ready, 1'b0);
        tick();
        @(negedge clk);
        check("zero_idle_c3", busy, 1'b0);
        check("zero_update_count", update_count, 0);
        tick();

        // ---------------- reset mid-RUN ----------------
        ready_mode = 2;
        node_cost  = 32'd1;
        node_addr  = 32'h99;
        edge_count = 16'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        edge_valid    = 1'b1;
        edge_dst      = 32'd7;
        edge_weight   = 32'd1;
        edge_dst_cost = 32'd100;
        tick();
        tick();
        edge_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_edge_ready", edge_ready, 1'b0);
        check("mid_rst_write_valid", write_valid, 1'b0);
        check("mid_rst_write_addr", write_addr, 0);
        check("mid_rst_next_cost", next_cost, 0);
        check("mid_rst_parent_addr", parent_addr, 0);
        check("mid_rst_update_count", update_count, 0);
        tick();
        exp_q.delete();
        ready_mode = 0;
        clear_edges();
        add_edge(32'd5, 32'd2, 32'd50);
        add_edge(32'd6, 32'd3, 32'd2);
        run_node(32'd20, 32'h31, 1'b0, 0);
        check("post_rst_update_count", update_count, 1);

        // ---------------- randomized nodes ----------------
        ready_mode = 1;
        for (int nd = 0; nd < 25; nd++) begin
            logic [W_D-1:0] c;
            int n;
            c = ($urandom_range(0, 4) == 0) ? (32'hFFFF_FF00 + $urandom_range(0, 255))
                                            : 32'($urandom_range(0, 1000));
            n = $urandom_range(0, 10);
            clear_edges();
            for (int i = 0; i < n; i++) begin
                logic [W_D-1:0] w, dc;
                w = 32'($urandom_range(0, 500));
                case ($urandom_range(0, 3))
                    0:       dc = COST_INF;
                    1:       dc = model_sum(c, w);
                    default: dc = 32'($urandom_range(0, 2000));
                endcase
                add_edge($urandom, w, dc);
            end
            run_node(c, $urandom, 1'b1,
                     ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
